// File: rtl/fifo_read_ctrl.sv
// Read side of a RAM-based FIFO: issues RAM reads, absorbs the one-cycle RAM latency
// with a one-word skid register, and presents a show-ahead head word to the consumer.
module fifo_read_ctrl #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3,
  parameter int AE_LVL = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W:0]   wr_ptr,
  input  logic [DATA_W-1:0] q_b,
  input  logic              pop,
  output logic              re_b,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W:0]   rd_ptr,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W+1:0] fill,
  output logic              underflow
);

  localparam logic [ADDR_W:0]   PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W+1:0] AE_THR  = (ADDR_W+2)'(AE_LVL);

  logic [ADDR_W:0]   rd_ptr_reg;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] skid_reg;
  logic              valid_reg;
  logic              skid_v_reg;
  logic              pend_reg;

  logic [ADDR_W:0]   mem_cnt;
  logic [1:0]        occ;
  logic [1:0]        occ_after;
  logic              take;

  // Modular pointer difference; equal addresses with differing wrap bits yields 2^ADDR_W.
  assign mem_cnt   = wr_ptr - rd_ptr_reg;
  assign occ       = {1'b0, valid_reg} + {1'b0, skid_v_reg} + {1'b0, pend_reg};
  assign take      = pop && valid_reg;
  assign occ_after = occ - {1'b0, take};

  assign re_b         = !reset && (mem_cnt != '0) && (occ_after < 2'd2);
  assign addr_b       = rd_ptr_reg[ADDR_W-1:0];
  assign rd_ptr       = rd_ptr_reg;
  assign data_out     = data_reg;
  assign valid        = valid_reg;
  assign empty        = !valid_reg;
  assign fill         = {1'b0, mem_cnt} + {{ADDR_W{1'b0}}, occ};
  assign almost_empty = (fill <= AE_THR);
  assign underflow    = !reset && pop && !valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      data_reg   <= '0;
      skid_reg   <= '0;
      valid_reg  <= 1'b0;
      skid_v_reg <= 1'b0;
      pend_reg   <= 1'b0;
    end else begin
      if (re_b) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      pend_reg <= re_b;
      if (take) begin
        // Head consumed: promote skid first so write order is kept.
        if (skid_v_reg) begin
          data_reg <= skid_reg;
          if (pend_reg) skid_reg <= q_b;
          else skid_v_reg <= 1'b0;
        end else if (pend_reg) begin
          data_reg <= q_b;
        end else begin
          valid_reg <= 1'b0;
        end
      end else if (pend_reg) begin
        if (!valid_reg) begin
          data_reg  <= q_b;
          valid_reg <= 1'b1;
        end else begin
          skid_reg   <= q_b;
          skid_v_reg <= 1'b1;
        end
      end
    end
  end

endmodule
